// File: rtl/sqrt_pkg.sv
// sqrt_pkg: shared state encoding, default sizes and counter sizing for the square-root unit
package sqrt_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_TAG_W = 5;

    function automatic int cnt_w(input int width);
        return $clog2(width / 2);
    endfunction

endpackage

// File: rtl/sqrt_step.sv
// sqrt_step: one combinational restoring square-root iteration (two radicand bits in, one root bit out)
module sqrt_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH/2+1:0] rem_i,
    input  logic [WIDTH/2-1:0] root_i,
    input  logic [1:0]         bits_i,
    output logic [WIDTH/2+1:0] rem_o,
    output logic [WIDTH/2-1:0] root_o
);
    localparam int HW = WIDTH / 2;

    logic [HW+1:0] rem_sh;
    logic [HW+1:0] trial;
    logic          ge;

    assign rem_sh = (rem_i << 2) | {{HW{1'b0}}, bits_i};
    assign trial  = {root_i, 2'b01};
    assign ge     = rem_sh >= trial;
    assign rem_o  = ge ? rem_sh - trial : rem_sh;
    assign root_o = (root_i << 1) | {{(HW-1){1'b0}}, ge};

endmodule

// File: rtl/int_sqrt_unit.sv
// int_sqrt_unit: iterative integer square root, one root bit per cycle, valid/ready request and response
module int_sqrt_unit
    import sqrt_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int TAG_W = DEF_TAG_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [WIDTH-1:0]   req_radicand,
    input  logic [TAG_W-1:0]   req_tag,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [WIDTH/2-1:0] resp_root,
    output logic [WIDTH/2:0]   resp_rem,
    output logic [TAG_W-1:0]   resp_tag,
    output logic               busy
);
    localparam int HW = WIDTH / 2;
    localparam int CW = cnt_w(WIDTH);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [HW+1:0] rem_q, rem_d, step_rem;
    logic [HW-1:0] root_q, root_d, step_root;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic          accept;

    sqrt_step #(.WIDTH(WIDTH)) u_step (
        .rem_i  (rem_q),
        .root_i (root_q),
        .bits_i (sh_q[WIDTH-1 -: 2]),
        .rem_o  (step_rem),
        .root_o (step_root)
    );

    assign req_ready  = (state_q == IDLE || (state_q == DONE && resp_ready)) && !flush;
    assign accept     = req_valid && req_ready;
    assign resp_valid = state_q == DONE;
    assign busy       = state_q != IDLE;
    assign resp_root  = root_q;
    assign resp_rem   = (HW+1)'(rem_q);
    assign resp_tag   = tag_q;

    // next state: flush beats accept, accept beats iteration and response handshake
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        rem_d   = rem_q;
        root_d  = root_q;
        tag_d   = tag_q;
        if (flush) begin
            state_d = IDLE;
        end else if (accept) begin
            state_d = CALC;
            cnt_d   = '0;
            sh_d    = req_radicand;
            rem_d   = '0;
            root_d  = '0;
            tag_d   = req_tag;
        end else if (state_q == CALC) begin
            rem_d   = step_rem;
            root_d  = step_root;
            sh_d    = sh_q << 2;
            cnt_d   = cnt_q + 1'b1;
            state_d = cnt_q == CW'(HW - 1) ? DONE : CALC;
        end else if (state_q == DONE && resp_ready) begin
            state_d = IDLE;
        end
    end

    // state and datapath registers, cleared asynchronously so outputs are never X
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            rem_q   <= '0;
            root_q  <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            rem_q   <= rem_d;
            root_q  <= root_d;
            tag_q   <= tag_d;
        end
    end

endmodule

// File: tb/tb_int_sqrt_unit.sv
// tb_int_sqrt_unit: directed and random checks of int_sqrt_unit against an arithmetic square-root model
module tb_int_sqrt_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_radicand = '0;
    logic [4:0]  req_tag = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [15:0] resp_root;
    logic [16:0] resp_rem;
    logic [4:0]  resp_tag;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    int_sqrt_unit #(.WIDTH(32), .TAG_W(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_radicand (req_radicand),
        .req_tag      (req_tag),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_root    (resp_root),
        .resp_rem     (resp_rem),
        .resp_tag     (resp_tag),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void ref_sqrt(input logic [31:0] x, output logic [15:0] r, output logic [16:0] m);
        longint xx = longint'(x);
        longint rr = longint'($sqrt(real'(xx)));
        longint mm;
        while (rr * rr > xx) rr--;
        while ((rr + 1) * (rr + 1) <= xx) rr++;
        mm = xx - rr * rr;
        r = rr[15:0];
        m = mm[16:0];
    endfunction

    task automatic accept(input logic [31:0] x, input logic [4:0] t);
        req_valid = 1'b1;
        req_radicand = x;
        req_tag = t;
        #1;
        chk("req_ready_at_accept", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input logic [31:0] x, input logic [4:0] t);
        int lat = 0;
        logic [15:0] r;
        logic [16:0] m;
        ref_sqrt(x, r, m);
        chk("busy_in_calc", busy, 1);
        chk("req_ready_in_calc", req_ready, 0);
        while (!resp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, 16);
        chk("root", resp_root, r);
        chk("rem", resp_rem, m);
        chk("tag", resp_tag, t);
    endtask

    task automatic hold_resp(input logic [31:0] x, input logic [4:0] t, input int n);
        logic [15:0] r;
        logic [16:0] m;
        ref_sqrt(x, r, m);
        resp_ready = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            chk("hold_valid", resp_valid, 1);
            chk("hold_root", resp_root, r);
            chk("hold_rem", resp_rem, m);
            chk("hold_tag", resp_tag, t);
            chk("hold_req_ready", req_ready, 0);
        end
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk("valid_after_handshake", resp_valid, 0);
        chk("req_ready_after_handshake", req_ready, 1);
    endtask

    task automatic full_op(input logic [31:0] x, input logic [4:0] t, input int hold);
        if (hold > 0) resp_ready = 1'b0;
        accept(x, t);
        wait_resp(x, t);
        if (hold > 0) hold_resp(x, t, hold);
        finish_resp();
    endtask

    initial begin
        logic [31:0] x;
        logic [15:0] v;
        #12;
        chk("rst_valid", resp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_root", resp_root, 0);
        chk("rst_rem", resp_rem, 0);
        chk("rst_tag", resp_tag, 0);
        chk("rst_req_ready", req_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        resp_ready = 1'b1;
        full_op(32'd144, 5'd3, 0);
        full_op(32'hFFFF_FFFF, 5'd4, 0);
        full_op(32'd0, 5'd5, 0);
        full_op(32'd2, 5'd6, 0);

        resp_ready = 1'b0;
        accept(32'd1000, 5'd12);
        wait_resp(32'd1000, 5'd12);
        hold_resp(32'd1000, 5'd12, 10);
        resp_ready = 1'b1;
        accept(32'd99, 5'd13);
        resp_ready = 1'b0;
        wait_resp(32'd99, 5'd13);
        finish_resp();

        accept(32'd500, 5'd7);
        repeat (7) @(posedge clk);
        #1;
        flush = 1'b1;
        #1;
        chk("flush_req_ready", req_ready, 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_busy", busy, 0);
        chk("flush_valid", resp_valid, 0);
        accept(32'd49, 5'd8);
        wait_resp(32'd49, 5'd8);
        finish_resp();

        accept(32'd12345, 5'd9);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", resp_valid, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_root", resp_root, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        full_op(32'd16, 5'd10, 0);

        accept(32'd77, 5'd11);
        wait_resp(32'd77, 5'd11);
        resp_ready = 1'b1;
        flush = 1'b1;
        req_valid = 1'b1;
        req_radicand = 32'd5;
        req_tag = 5'd14;
        #1;
        chk("flush_done_req_ready", req_ready, 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        req_valid = 1'b0;
        resp_ready = 1'b0;
        chk("flush_done_valid", resp_valid, 0);
        chk("flush_done_busy", busy, 0);

        for (int i = 0; i < 24; i++) begin
            x = $urandom;
            if (i % 4 == 0) x = $urandom_range(0, 1000);
            if (i % 4 == 1) begin
                v = 16'($urandom_range(0, 65535));
                x = {16'd0, v} * {16'd0, v};
            end
            full_op(x, 5'(i), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
